// File: rtl/dino_pkg.sv
// Shared definitions for the dino game datapath: position width, scheduler states, LFSR constants.
package dino_pkg;

    localparam int POS_W = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/obstacle_scheduler_gap_lfsr.sv
// 16-bit Galois LFSR feeding random spawn gaps and sprite variants.
// Only instantiated when RANDOM_GAP_EN is defined.
module gap_lfsr
    import dino_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_en,
    output logic [15:0] o_state
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_en) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign o_state = r_lfsr;

endmodule

// File: rtl/obstacle_scheduler.sv
// Spawns, scrolls and retires cactus obstacles against the 11-bit scroll position.
// Optional RANDOM_GAP_EN: random gap/type from gap_lfsr; otherwise fixed mid-range gap, type 0.
module obstacle_scheduler
    import dino_pkg::*;
#(
    parameter int NUM_SLOTS      = 3,
    parameter int SCREEN_W       = 640,
    parameter int OBS_W          = 20,
    parameter int MIN_GAP        = 200,
    parameter int GAP_RANGE_BITS = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       halt,
    input  logic [POS_W-1:0]           pos,
    output logic [NUM_SLOTS-1:0]       obs_valid,
    output logic [POS_W*NUM_SLOTS-1:0] obs_x,
    output logic [2*NUM_SLOTS-1:0]     obs_type,
    output logic                       spawn_pulse,
    output logic                       overflow
);

    localparam logic [POS_W-1:0] SPAWN_X    = POS_W'(SCREEN_W);
    localparam logic [POS_W-1:0] RETIRE_LIM = POS_W'(SCREEN_W + OBS_W);
    localparam logic [POS_W-1:0] FIRST_GAP  = POS_W'(MIN_GAP);
    localparam logic [POS_W-1:0] HALF_RANGE = POS_W'(1024);

    if ((SCREEN_W + OBS_W) >= 1024) begin : g_bad_screen
        $error("obstacle_scheduler: SCREEN_W+OBS_W must be below 1024");
    end
    if ((MIN_GAP + (2 ** GAP_RANGE_BITS)) >= 1024) begin : g_bad_gap
        $error("obstacle_scheduler: MIN_GAP+2^GAP_RANGE_BITS must be below 1024");
    end

    state_t                 r_state;
    logic [NUM_SLOTS-1:0]   r_valid;
    logic [POS_W-1:0]       r_spawn_pos [NUM_SLOTS];
    logic [POS_W-1:0]       r_x         [NUM_SLOTS];
    logic [1:0]             r_type      [NUM_SLOTS];
    logic [POS_W-1:0]       r_next_spawn;
    logic                   r_spawn_pulse;
    logic                   r_overflow;

    logic [POS_W-1:0]       w_gap;
    logic [1:0]             w_type;
    logic [POS_W-1:0]       w_reach_diff;
    logic                   w_reached;
    logic [POS_W-1:0]       w_dist      [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   w_retire;
    logic [NUM_SLOTS-1:0]   w_spawn_sel;
    logic                   w_any_free;

`ifdef RANDOM_GAP_EN
    logic [15:0] w_lfsr;

    gap_lfsr u_gap_lfsr (
        .clk     (clk),
        .reset   (reset),
        .i_en    (1'b1),
        .o_state (w_lfsr)
    );

    assign w_gap  = FIRST_GAP + POS_W'(w_lfsr[GAP_RANGE_BITS-1:0]);
    assign w_type = w_lfsr[9:8];
`else
    assign w_gap  = POS_W'(MIN_GAP + (2 ** (GAP_RANGE_BITS - 1)));
    assign w_type = 2'd0;
`endif

    // Modular "pos at or past next_spawn": the difference lands in the lower half of the ring.
    assign w_reach_diff = pos - r_next_spawn;
    assign w_reached    = (w_reach_diff < HALF_RANGE);

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        assign w_dist[g]   = pos - r_spawn_pos[g];
        assign w_retire[g] = r_valid[g] && (w_dist[g] > RETIRE_LIM);
        assign obs_x[POS_W*g +: POS_W] = r_x[g];
        assign obs_type[2*g +: 2]      = r_type[g];
    end

    // Lowest slot free at the start of the cycle; slots retiring now are still counted as busy.
    always_comb begin
        w_any_free  = 1'b0;
        w_spawn_sel = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!r_valid[i] && !w_any_free) begin
                w_spawn_sel[i] = w_reached;
                w_any_free     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_valid       <= '0;
            r_next_spawn  <= '0;
            r_spawn_pulse <= 1'b0;
            r_overflow    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_spawn_pos[i] <= '0;
                r_x[i]         <= '0;
                r_type[i]      <= '0;
            end
        end else begin
            r_spawn_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_valid <= '0;
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        r_x[i] <= '0;
                    end
                    if (start) begin
                        r_next_spawn <= pos + FIRST_GAP;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    if (halt) begin
                        r_state <= FROZEN;
                    end else begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (w_spawn_sel[i]) begin
                                r_valid[i]     <= 1'b1;
                                r_spawn_pos[i] <= pos;
                                r_type[i]      <= w_type;
                                r_x[i]         <= SPAWN_X;
                            end else if (r_valid[i] && !w_retire[i]) begin
                                r_x[i] <= SPAWN_X - w_dist[i];
                            end else begin
                                r_valid[i] <= 1'b0;
                                r_x[i]     <= '0;
                            end
                        end
                        if (w_reached) begin
                            if (w_any_free) begin
                                r_next_spawn  <= pos + w_gap;
                                r_spawn_pulse <= 1'b1;
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end
                    end
                end
                FROZEN: begin
                    if (!halt) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign obs_valid   = r_valid;
    assign spawn_pulse = r_spawn_pulse;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: default instance plus a small-gap instance for overflow.
module tb_obstacle_scheduler;

    logic        clk;
    logic        reset_a;
    logic        reset_b;
    logic        start;
    logic        halt;
    logic [10:0] pos;

    logic [2:0]  obs_valid_a, obs_valid_b;
    logic [32:0] obs_x_a, obs_x_b;
    logic [5:0]  obs_type_a, obs_type_b;
    logic        spawn_pulse_a, spawn_pulse_b;
    logic        overflow_a, overflow_b;

    int n_total;
    int n_pass;
    int n_fail;
    int cur;

    obstacle_scheduler u_dut_a (
        .clk         (clk),
        .reset       (reset_a),
        .start       (start),
        .halt        (halt),
        .pos         (pos),
        .obs_valid   (obs_valid_a),
        .obs_x       (obs_x_a),
        .obs_type    (obs_type_a),
        .spawn_pulse (spawn_pulse_a),
        .overflow    (overflow_a)
    );

    obstacle_scheduler #(
        .MIN_GAP        (64),
        .GAP_RANGE_BITS (1)
    ) u_dut_b (
        .clk         (clk),
        .reset       (reset_b),
        .start       (start),
        .halt        (halt),
        .pos         (pos),
        .obs_valid   (obs_valid_b),
        .obs_x       (obs_x_b),
        .obs_type    (obs_type_b),
        .spawn_pulse (spawn_pulse_b),
        .overflow    (overflow_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step_to(input int target);
        int n;
        n = 0;
        while (cur != target && n < 1100) begin
            cur = (cur + 2) % 2048;
            pos = 11'(cur);
            tick();
            n++;
        end
        if (cur != target) begin
            n_total++;
            n_fail++;
            $display("FAIL step_to: observed pos %0d, expected %0d", cur, target);
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        start   = 1'b0;
        halt    = 1'b0;
        pos     = '0;
        cur     = 0;
        tick();
        tick();
        reset_a = 1'b0;
        tick();
        chk("reset_valid", 36'(obs_valid_a), 36'd0);
        chk("reset_x", 36'(obs_x_a), 36'd0);
        chk("reset_type", 36'(obs_type_a), 36'd0);
        chk("reset_pulse", 36'(spawn_pulse_a), 36'd0);
        chk("reset_ovf", 36'(overflow_a), 36'd0);

        // IDLE ignores scrolling
        step_to(300);
        chk("idle_no_spawn", 36'(obs_valid_a), 36'd0);

        // First spawn
        cur = 0;
        pos = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        step_to(198);
        chk("pre_spawn_valid", 36'(obs_valid_a), 36'd0);
        chk("pre_spawn_pulse", 36'(spawn_pulse_a), 36'd0);
        step_to(200);
        chk("spawn_pulse", 36'(spawn_pulse_a), 36'd1);
        chk("spawn_valid", 36'(obs_valid_a), 36'd1);
        chk("spawn_x0", 36'(obs_x_a[10:0]), 36'd640);
        chk("spawn_type0", 36'(obs_type_a[1:0]), 36'd0);
        step_to(202);
        chk("pulse_one_cycle", 36'(spawn_pulse_a), 36'd0);

        // Scroll and retire
        step_to(400);
        chk("scroll_x0", 36'(obs_x_a[10:0]), 36'd440);
        step_to(462);
        chk("before_next_spawn", 36'(obs_valid_a), 36'd1);
        step_to(464);
        chk("second_spawn_pulse", 36'(spawn_pulse_a), 36'd1);
        chk("second_spawn_valid", 36'(obs_valid_a), 36'd3);
        chk("second_spawn_x1", 36'(obs_x_a[21:11]), 36'd640);
        step_to(860);
        chk("edge_not_retired", 36'(obs_valid_a), 36'd7);
        chk("edge_x0_neg", 36'(obs_x_a[10:0]), 36'd2028);
        step_to(862);
        chk("retired_valid", 36'(obs_valid_a), 36'd6);
        chk("retired_x0", 36'(obs_x_a[10:0]), 36'd0);

        // Reset mid-run
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        chk("midreset_valid", 36'(obs_valid_a), 36'd0);
        chk("midreset_ovf", 36'(overflow_a), 36'd0);
        chk("midreset_pulse", 36'(spawn_pulse_a), 36'd0);
        chk("midreset_x", 36'(obs_x_a), 36'd0);
        step_to(1200);
        chk("midreset_idle", 36'(obs_valid_a), 36'd0);

        // Wrap-around
        step_to(1898);
        start = 1'b1;
        step_to(1900);
        start = 1'b0;
        step_to(50);
        chk("wrap_pre_valid", 36'(obs_valid_a), 36'd0);
        step_to(52);
        chk("wrap_pulse", 36'(spawn_pulse_a), 36'd1);
        chk("wrap_valid", 36'(obs_valid_a), 36'd1);
        chk("wrap_x0", 36'(obs_x_a[10:0]), 36'd640);
        step_to(100);
        chk("wrap_x0_100", 36'(obs_x_a[10:0]), 36'd592);

        // Simultaneous reset and start: reset wins
        reset_a = 1'b1;
        start = 1'b1;
        tick();
        reset_a = 1'b0;
        start = 1'b0;
        cur = 0;
        pos = '0;
        step_to(300);
        chk("rst_start_valid", 36'(obs_valid_a), 36'd0);
        chk("rst_start_pulse", 36'(spawn_pulse_a), 36'd0);

        // Halt
        cur = 0;
        pos = '0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        step_to(188);
        halt = 1'b1;
        step_to(190);
        pos = 11'd210;
        cur = 210;
        tick();
        tick();
        chk("halt_no_pulse", 36'(spawn_pulse_a), 36'd0);
        chk("halt_no_valid", 36'(obs_valid_a), 36'd0);
        halt = 1'b0;
        tick();
        chk("release_first", 36'(spawn_pulse_a), 36'd0);
        tick();
        chk("release_second", 36'(spawn_pulse_a), 36'd1);
        chk("release_valid", 36'(obs_valid_a), 36'd1);
        chk("release_x0", 36'(obs_x_a[10:0]), 36'd640);
        halt = 1'b1;
        pos = 11'd230;
        tick();
        pos = 11'd260;
        cur = 260;
        tick();
        chk("halt_hold_x0", 36'(obs_x_a[10:0]), 36'd640);
        chk("halt_hold_valid", 36'(obs_valid_a), 36'd1);
        halt = 1'b0;
        tick();
        tick();
        chk("resume_x0", 36'(obs_x_a[10:0]), 36'd590);

        // Overflow on the small-gap instance
        reset_a = 1'b1;
        cur = 0;
        pos = '0;
        reset_b = 1'b0;
        tick();
        chk("b_reset_x", 36'(obs_x_b), 36'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        step_to(196);
        chk("b_full_valid", 36'(obs_valid_b), 36'd7);
        chk("b_slot2_x", 36'(obs_x_b[32:22]), 36'd640);
        chk("b_slot2_pulse", 36'(spawn_pulse_b), 36'd1);
        step_to(260);
        chk("b_pre_ovf", 36'(overflow_b), 36'd0);
        step_to(262);
        chk("b_ovf", 36'(overflow_b), 36'd1);
        chk("b_ovf_no_pulse", 36'(spawn_pulse_b), 36'd0);
        chk("b_ovf_valid", 36'(obs_valid_b), 36'd7);
        step_to(724);
        chk("b_724_valid", 36'(obs_valid_b), 36'd7);
        step_to(726);
        chk("b_retire_valid", 36'(obs_valid_b), 36'd6);
        chk("b_retire_no_pulse", 36'(spawn_pulse_b), 36'd0);
        step_to(728);
        chk("b_respawn_pulse", 36'(spawn_pulse_b), 36'd1);
        chk("b_respawn_valid", 36'(obs_valid_b), 36'd7);
        chk("b_respawn_x0", 36'(obs_x_b[10:0]), 36'd640);
        chk("b_ovf_sticky", 36'(overflow_b), 36'd1);
        chk("b_type", 36'(obs_type_b), 36'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
